// File: rtl/uart_tx_engine_pkg.sv
// Shared definitions for the UART transmit engine: frame states and default widths.
package uart_tx_engine_pkg;

    localparam int unsigned DEF_DATA_BITS = 8;
    localparam int unsigned DEF_DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_engine_if.sv
// Byte/handshake and serial-line bundle between a byte producer and the UART transmitter.
interface uart_tx_engine_if
    import uart_tx_engine_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned DIV_WIDTH = DEF_DIV_WIDTH
);
    logic [DIV_WIDTH-1:0] N;
    logic                 start;
    logic [DATA_BITS-1:0] data_in;
    logic                 tx;
    logic                 busy;
    logic                 done;

    modport master (
        output N, start, data_in,
        input  tx, busy, done
    );

    modport slave (
        input  N, start, data_in,
        output tx, busy, done
    );
endinterface

// File: rtl/uart_tx_engine_bit_timer.sv
// Loadable down-counter that marks the final clock of each serial bit period.
module uart_bit_timer
    import uart_tx_engine_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             bit_end
);
    logic [WIDTH-1:0] r_count;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign bit_end = (r_count == '0);
endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, DATA_BITS LSB-first, one stop bit, each held Nq clocks.
module uart_tx_engine
    import uart_tx_engine_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned DIV_WIDTH = DEF_DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_engine_if.slave    bus
);
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    tx_state_t            r_state;
    tx_state_t            w_state_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DIV_WIDTH-1:0] r_nq;
    logic [DIV_WIDTH-1:0] w_n_eff;
    logic [DIV_WIDTH-1:0] w_load_val;
    logic                 r_tx, r_busy, r_done;
    logic                 w_tx_next, w_busy_next, w_done_next;
    logic                 w_accept, w_load, w_bit_end, w_last_bit;

    assign w_accept     = (r_state == ST_IDLE) && bus.start;
    // A zero divisor would give an empty bit period, so it is treated as one clock.
    assign w_n_eff      = (bus.N == '0) ? DIV_WIDTH'(1) : bus.N;
    assign w_load       = w_accept || ((r_state != ST_IDLE) && w_bit_end);
    assign w_load_val   = w_accept ? (w_n_eff - DIV_WIDTH'(1)) : (r_nq - DIV_WIDTH'(1));
    assign w_last_bit   = (r_bit_idx == IDX_W'(DATA_BITS - 1));
    assign w_shift_next = r_shift >> 1;

    uart_bit_timer #(
        .WIDTH(DIV_WIDTH)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .bit_end  (w_bit_end)
    );

    // State and registered line outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // Next state and next line values; tx is computed one clock ahead so it is registered.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_START;
                    w_tx_next    = 1'b0;
                    w_busy_next  = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next = ST_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (w_last_bit) begin
                        w_state_next = ST_STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_tx_next    = w_shift_next[0];
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_next = ST_IDLE;
                    w_tx_next    = 1'b1;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // Payload, divisor and bit-index capture on accept; shift at each data bit end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_nq      <= '0;
        end else if (w_accept) begin
            r_shift   <= bus.data_in;
            r_bit_idx <= '0;
            r_nq      <= w_n_eff;
        end else if ((r_state == ST_DATA) && w_bit_end) begin
            r_shift   <= w_shift_next;
            if (!w_last_bit) begin
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
        end
    end

    assign bus.tx   = r_tx;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: per-cycle scoreboard of tx/busy/done.
module tb_uart_tx_engine;

    logic clk;
    logic rst;

    uart_tx_engine_if #(.DATA_BITS(8), .DIV_WIDTH(8)) bus ();

    uart_tx_engine #(.DATA_BITS(8), .DIV_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic tx;
        logic busy;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Expected line level k clocks after the accept edge for an 8N1 frame.
    function automatic logic exp_tx(input logic [7:0] data, input int nq, input int k);
        int b;
        b = k / nq;
        if (b == 0) return 1'b0;
        if (b <= 8) return data[b-1];
        return 1'b1;
    endfunction

    // Queue one frame: 10*Nq busy samples, the done sample, optionally one idle sample.
    task automatic push_frame(input logic [7:0] n, input logic [7:0] data, input bit tail_idle);
        int   nq;
        exp_t e;
        nq = (n == 8'd0) ? 1 : int'(n);
        for (int k = 0; k < 10 * nq; k++) begin
            e.tx = exp_tx(data, nq, k); e.busy = 1'b1; e.done = 1'b0;
            exp_q.push_back(e);
        end
        e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b1;
        exp_q.push_back(e);
        if (tail_idle) begin
            e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Compare one queued entry per clock; optional mid-frame input disturbance.
    task automatic drain(input string name, input int mut_at, input int drop_at);
        exp_t e;
        int   idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({bus.tx, bus.busy, bus.done} !== {e.tx, e.busy, e.done})
                $display("FAIL %s sample %0d: tx/busy/done=%b%b%b expected %b%b%b",
                         name, idx, bus.tx, bus.busy, bus.done, e.tx, e.busy, e.done);
            else
                n_pass++;
            if (mut_at >= 0 && idx == mut_at) begin
                bus.N = 8'd7; bus.data_in = 8'hFF; bus.start = 1'b1;
            end
            if (mut_at >= 0 && idx == mut_at + 2) bus.start = 1'b0;
            if (idx == drop_at) bus.start = 1'b0;
            idx++;
            @(posedge clk); #1;
        end
    endtask

    // Present a request; returns at the sample point just after the accept edge.
    task automatic launch(input logic [7:0] n, input logic [7:0] data, input bit hold);
        bus.N = n; bus.data_in = data; bus.start = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            n_checks++;
            if ({bus.tx, bus.busy, bus.done} !== 3'b100)
                $display("FAIL %s cycle %0d: tx/busy/done=%b%b%b expected 100",
                         name, i, bus.tx, bus.busy, bus.done);
            else
                n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        check_idle("por_idle", 3);
        launch(8'd4, 8'hA5, 1'b0);
        // Run into data bit 3 (samples 16..19), stop at sample 17.
        for (int k = 0; k < 18; k++) begin
            n_checks++;
            if ({bus.tx, bus.busy} !== {exp_tx(8'hA5, 4, k), 1'b1})
                $display("FAIL pre_reset k=%0d: tx/busy=%b%b expected %b1",
                         k, bus.tx, bus.busy, exp_tx(8'hA5, 4, k));
            else
                n_pass++;
            if (k < 17) begin
                @(posedge clk); #1;
            end
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.tx, bus.busy, bus.done} !== 3'b100)
            $display("FAIL async_reset: tx/busy/done=%b%b%b expected 100", bus.tx, bus.busy, bus.done);
        else
            n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("post_reset_idle", 20);
    endtask

    task automatic test_basic();
        launch(8'd4, 8'h5A, 1'b0);
        push_frame(8'd4, 8'h5A, 1'b1);
        drain("basic_n4_5a", -1, -1);
    endtask

    task automatic test_min_div();
        launch(8'd1, 8'hFF, 1'b0);
        push_frame(8'd1, 8'hFF, 1'b1);
        drain("n1_ff", -1, -1);
        launch(8'd0, 8'hFF, 1'b0);
        push_frame(8'd0, 8'hFF, 1'b1);
        drain("n0_ff", -1, -1);
    endtask

    task automatic test_max_div();
        launch(8'd255, 8'h00, 1'b0);
        push_frame(8'd255, 8'h00, 1'b1);
        drain("n255_00", -1, -1);
    endtask

    task automatic test_back_to_back();
        launch(8'd4, 8'h11, 1'b1);
        bus.data_in = 8'h22;
        push_frame(8'd4, 8'h11, 1'b0);
        push_frame(8'd4, 8'h22, 1'b1);
        // start stays high through both frames, dropped on the second done sample.
        drain("back_to_back", -1, 81);
    endtask

    task automatic test_stability();
        launch(8'd4, 8'h3C, 1'b0);
        push_frame(8'd4, 8'h3C, 1'b1);
        drain("stability", 10, -1);
        bus.N = 8'd2; bus.data_in = 8'hC3;
        launch(8'd2, 8'hC3, 1'b0);
        push_frame(8'd2, 8'hC3, 1'b1);
        drain("after_stability", -1, -1);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.N = '0;
        bus.data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.tx, bus.busy, bus.done} !== 3'b100)
            $display("FAIL in_reset: tx/busy/done=%b%b%b expected 100", bus.tx, bus.busy, bus.done);
        else
            n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_min_div();
        test_max_div();
        test_back_to_back();
        test_stability();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
